// File: rtl/mcx_core.sv
// mcx_core: small accumulator core with a writable program memory, simple
// clamped I/O pins, blocking XBus channels with valid/ready handshakes, and a
// tick-driven sleep instruction.
// Optional feature macro: MCX_MUL_EN (enables the mul opcode and its multiplier;
// without it opcode 4 executes as nop).
module mcx_core #(
    parameter int DATA_W     = 11,
    parameter int PROG_DEPTH = 16,
    parameter int NUM_P      = 2,
    parameter int NUM_X      = 2,
    localparam int AW = $clog2(PROG_DEPTH),
    localparam int IW = 2 * DATA_W + 12
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    tick,
    input  logic                    prog_we,
    input  logic [AW-1:0]           prog_addr,
    input  logic [IW-1:0]           prog_data,
    input  logic [NUM_P*DATA_W-1:0] p_in,
    output logic [NUM_P*DATA_W-1:0] p_out,
    input  logic [NUM_X*DATA_W-1:0] xin_data,
    input  logic [NUM_X-1:0]        xin_valid,
    output logic [NUM_X-1:0]        xin_ready,
    output logic [NUM_X*DATA_W-1:0] xout_data,
    output logic [NUM_X-1:0]        xout_valid,
    input  logic [NUM_X-1:0]        xout_ready,
    output logic [AW-1:0]           pc,
    output logic                    sleeping
);

    localparam int WW = 2 * DATA_W + 2;
    localparam logic signed [DATA_W-1:0] SAT_MAX = DATA_W'(999);
    localparam logic signed [DATA_W-1:0] SAT_MIN = DATA_W'(-999);
    localparam logic signed [DATA_W-1:0] P_MAX   = DATA_W'(100);
    localparam logic signed [DATA_W-1:0] ZERO    = '0;
    localparam logic [3:0] P_LO = 4'd2;
    localparam logic [3:0] X_LO = 4'(2 + NUM_P);
    localparam logic [3:0] X_HI = 4'(2 + NUM_P + NUM_X);

    localparam logic [3:0] OP_MOV = 4'd1;
    localparam logic [3:0] OP_ADD = 4'd2;
    localparam logic [3:0] OP_SUB = 4'd3;
`ifdef MCX_MUL_EN
    localparam logic [3:0] OP_MUL = 4'd4;
`endif
    localparam logic [3:0] OP_NOT = 4'd5;
    localparam logic [3:0] OP_TEQ = 4'd6;
    localparam logic [3:0] OP_TGT = 4'd7;
    localparam logic [3:0] OP_TLT = 4'd8;
    localparam logic [3:0] OP_TCP = 4'd9;
    localparam logic [3:0] OP_SLP = 4'd10;
    localparam logic [3:0] OP_JMP = 4'd11;

    typedef enum logic [2:0] {
        ST_EXEC  = 3'd0,
        ST_RD_A  = 3'd1,
        ST_RD_B  = 3'd2,
        ST_WR_X  = 3'd3,
        ST_SLEEP = 3'd4
    } state_t;

    // Clamp a wide intermediate result into the -999..999 value range.
    function automatic logic signed [DATA_W-1:0] sat(input logic signed [WW-1:0] v);
        logic signed [DATA_W-1:0] r;
        if (v > WW'(SAT_MAX)) r = SAT_MAX;
        else if (v < WW'(SAT_MIN)) r = SAT_MIN;
        else r = v[DATA_W-1:0];
        return r;
    endfunction

    // Pins only carry 0..100.
    function automatic logic signed [DATA_W-1:0] clamp_p(input logic signed [DATA_W-1:0] v);
        logic signed [DATA_W-1:0] r;
        if (v < ZERO) r = ZERO;
        else if (v > P_MAX) r = P_MAX;
        else r = v;
        return r;
    endfunction

    // Non-blocking register read; x channels are handled by the RD states.
    function automatic logic signed [DATA_W-1:0] rd_reg(
        input logic [3:0]               code,
        input logic signed [DATA_W-1:0] acc,
        input logic signed [DATA_W-1:0] dat,
        input logic [NUM_P*DATA_W-1:0]  pins
    );
        logic signed [DATA_W-1:0] v;
        v = ZERO;
        if (code == 4'd0) v = acc;
        else if (code == 4'd1) v = dat;
        else begin
            for (int k = 0; k < NUM_P; k++) begin
                if (code == 4'(2 + k)) v = pins[k*DATA_W +: DATA_W];
                else v = v;
            end
        end
        return v;
    endfunction

    logic [IW-1:0] mem [PROG_DEPTH];

    state_t                     state_r;
    logic [AW-1:0]              pc_r;
    logic [IW-1:0]              ir_r;
    logic signed [DATA_W-1:0]   acc_r, dat_r, opa_r;
    logic [NUM_P*DATA_W-1:0]    p_out_r;
    logic [NUM_X*DATA_W-1:0]    xout_data_r;
    logic [NUM_X-1:0]           xout_valid_r, xin_ready_r;
    logic                       flag_p_r, flag_n_r;
    logic [DATA_W-1:0]          cnt_r;

    logic [IW-1:0]              instr_s;
    logic [1:0]                 cond_s;
    logic [3:0]                 op_s, dst_s;
    logic                       a_imm_s, b_imm_s;
    logic [DATA_W-1:0]          a_fld_s, b_fld_s;
    logic signed [DATA_W-1:0]   a_val_s, b_val_s, res_s;
    logic signed [WW-1:0]       alu_w_s;
    logic                       alu_wr_s, uses_a_s, uses_b_s, cond_ok_s;
    logic                       a_x_s, b_x_s, dst_x_s, dst_p_s;
    logic [1:0]                 a_ch_s, b_ch_s, d_ch_s, d_p_s;
    logic                       hs_a_s, hs_b_s, fin_s;
    logic                       cmp_eq_s, cmp_gt_s, cmp_lt_s;
    logic [AW-1:0]              pc_inc_s;

    // Program memory: write on the edge, read combinationally (old word on collision).
    always_ff @(posedge clk) begin
        if (prog_we) mem[prog_addr] <= prog_data;
    end

    // Decode the current instruction and work out stalls, operands and handshakes.
    always_comb begin
        instr_s  = (state_r == ST_EXEC) ? mem[pc_r] : ir_r;
        cond_s   = instr_s[IW-1 -: 2];
        op_s     = instr_s[IW-3 -: 4];
        a_imm_s  = instr_s[IW-7];
        b_imm_s  = instr_s[IW-8];
        dst_s    = instr_s[IW-9 -: 4];
        a_fld_s  = instr_s[2*DATA_W-1 -: DATA_W];
        b_fld_s  = instr_s[DATA_W-1:0];
        pc_inc_s = pc_r + AW'(1);

        case (op_s)
            OP_MOV, OP_ADD, OP_SUB, OP_SLP, OP_JMP: begin uses_a_s = 1'b1; uses_b_s = 1'b0; end
`ifdef MCX_MUL_EN
            OP_MUL: begin uses_a_s = 1'b1; uses_b_s = 1'b0; end
`endif
            OP_TEQ, OP_TGT, OP_TLT, OP_TCP: begin uses_a_s = 1'b1; uses_b_s = 1'b1; end
            default: begin uses_a_s = 1'b0; uses_b_s = 1'b0; end
        endcase

        case (cond_s)
            2'b00:   cond_ok_s = 1'b1;
            2'b01:   cond_ok_s = flag_p_r;
            2'b10:   cond_ok_s = flag_n_r;
            default: cond_ok_s = 1'b0;
        endcase

        a_x_s   = uses_a_s && !a_imm_s && (a_fld_s[3:0] >= X_LO) && (a_fld_s[3:0] < X_HI);
        b_x_s   = uses_b_s && !b_imm_s && (b_fld_s[3:0] >= X_LO) && (b_fld_s[3:0] < X_HI);
        dst_x_s = (op_s == OP_MOV) && (dst_s >= X_LO) && (dst_s < X_HI);
        dst_p_s = (dst_s >= P_LO) && (dst_s < X_LO);
        a_ch_s  = 2'(a_fld_s[3:0] - X_LO);
        b_ch_s  = 2'(b_fld_s[3:0] - X_LO);
        d_ch_s  = 2'(dst_s - X_LO);
        d_p_s   = 2'(dst_s - P_LO);
        hs_a_s  = xin_valid[a_ch_s] && xin_ready_r[a_ch_s];
        hs_b_s  = xin_valid[b_ch_s] && xin_ready_r[b_ch_s];

        if (state_r == ST_RD_A) a_val_s = xin_data[a_ch_s*DATA_W +: DATA_W];
        else if (state_r == ST_RD_B) a_val_s = opa_r;
        else if (a_imm_s) a_val_s = a_fld_s;
        else a_val_s = rd_reg(a_fld_s[3:0], acc_r, dat_r, p_in);

        if (state_r == ST_RD_B) b_val_s = xin_data[b_ch_s*DATA_W +: DATA_W];
        else if (b_imm_s) b_val_s = b_fld_s;
        else b_val_s = rd_reg(b_fld_s[3:0], acc_r, dat_r, p_in);

        fin_s = ((state_r == ST_EXEC) && cond_ok_s && !a_x_s && !b_x_s) ||
                ((state_r == ST_RD_A) && hs_a_s && !b_x_s) ||
                ((state_r == ST_RD_B) && hs_b_s);
    end

    // Arithmetic and compare results for the instruction being completed.
    always_comb begin
        cmp_eq_s = (a_val_s == b_val_s);
        cmp_gt_s = (a_val_s > b_val_s);
        cmp_lt_s = (a_val_s < b_val_s);
        case (op_s)
            OP_ADD: begin alu_w_s = WW'(acc_r) + WW'(a_val_s); alu_wr_s = 1'b1; end
            OP_SUB: begin alu_w_s = WW'(acc_r) - WW'(a_val_s); alu_wr_s = 1'b1; end
`ifdef MCX_MUL_EN
            OP_MUL: begin alu_w_s = WW'(acc_r) * WW'(a_val_s); alu_wr_s = 1'b1; end
`endif
            OP_NOT: begin alu_w_s = (acc_r == ZERO) ? WW'(P_MAX) : '0; alu_wr_s = 1'b1; end
            default: begin alu_w_s = WW'(a_val_s); alu_wr_s = 1'b0; end
        endcase
        res_s = sat(alu_w_s);
    end

    // Control FSM plus all architectural state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_EXEC;
            pc_r         <= '0;
            ir_r         <= '0;
            acc_r        <= '0;
            dat_r        <= '0;
            opa_r        <= '0;
            p_out_r      <= '0;
            xout_data_r  <= '0;
            xout_valid_r <= '0;
            xin_ready_r  <= '0;
            flag_p_r     <= 1'b0;
            flag_n_r     <= 1'b0;
            cnt_r        <= '0;
        end else begin
            case (state_r)
                ST_EXEC: begin
                    ir_r  <= instr_s;
                    opa_r <= a_val_s;
                    if (!cond_ok_s) begin
                        pc_r <= pc_inc_s;
                    end else if (a_x_s) begin
                        state_r <= ST_RD_A;
                        xin_ready_r[a_ch_s] <= 1'b1;
                    end else if (b_x_s) begin
                        state_r <= ST_RD_B;
                        xin_ready_r[b_ch_s] <= 1'b1;
                    end
                end
                ST_RD_A: begin
                    if (hs_a_s) begin
                        xin_ready_r[a_ch_s] <= 1'b0;
                        opa_r <= a_val_s;
                        if (b_x_s) begin
                            state_r <= ST_RD_B;
                            xin_ready_r[b_ch_s] <= 1'b1;
                        end
                    end
                end
                ST_RD_B: begin
                    if (hs_b_s) xin_ready_r[b_ch_s] <= 1'b0;
                end
                ST_WR_X: begin
                    if (xout_valid_r[d_ch_s] && xout_ready[d_ch_s]) begin
                        xout_valid_r[d_ch_s] <= 1'b0;
                        pc_r    <= pc_inc_s;
                        state_r <= ST_EXEC;
                    end
                end
                ST_SLEEP: begin
                    if (tick) begin
                        cnt_r <= cnt_r - DATA_W'(1);
                        if (cnt_r == DATA_W'(1)) begin
                            pc_r    <= pc_inc_s;
                            state_r <= ST_EXEC;
                        end
                    end
                end
                default: state_r <= ST_EXEC;
            endcase

            if (fin_s) begin
                state_r <= ST_EXEC;
                pc_r    <= pc_inc_s;
                if (alu_wr_s) acc_r <= res_s;
                case (op_s)
                    OP_MOV: begin
                        if (dst_x_s) begin
                            state_r <= ST_WR_X;
                            pc_r    <= pc_r;
                            xout_data_r[d_ch_s*DATA_W +: DATA_W] <= res_s;
                            xout_valid_r[d_ch_s] <= 1'b1;
                        end else if (dst_s == 4'd0) begin
                            acc_r <= res_s;
                        end else if (dst_s == 4'd1) begin
                            dat_r <= res_s;
                        end else if (dst_p_s) begin
                            p_out_r[d_p_s*DATA_W +: DATA_W] <= clamp_p(res_s);
                        end
                    end
                    OP_TEQ: begin flag_p_r <= cmp_eq_s; flag_n_r <= !cmp_eq_s; end
                    OP_TGT: begin flag_p_r <= cmp_gt_s; flag_n_r <= !cmp_gt_s; end
                    OP_TLT: begin flag_p_r <= cmp_lt_s; flag_n_r <= !cmp_lt_s; end
                    OP_TCP: begin flag_p_r <= cmp_gt_s; flag_n_r <= cmp_lt_s; end
                    OP_SLP: begin
                        if (a_val_s > ZERO) begin
                            state_r <= ST_SLEEP;
                            pc_r    <= pc_r;
                            cnt_r   <= a_val_s;
                        end
                    end
                    OP_JMP: pc_r <= a_val_s[AW-1:0];
                    default: pc_r <= pc_inc_s;
                endcase
            end
        end
    end

    assign pc         = pc_r;
    assign p_out      = p_out_r;
    assign xout_data  = xout_data_r;
    assign xout_valid = xout_valid_r;
    assign xin_ready  = xin_ready_r;
    assign sleeping   = (state_r == ST_SLEEP);

endmodule

// File: tb/tb_mcx_core.sv
// Bench for mcx_core: table of short programs checked through the pins and
// XBus output, plus hand-written multi-cycle sequences (XBus read stall,
// skipped conditionals, sleep/tick, reset during an XBus write).
module tb_mcx_core;

    localparam int DW = 11;
    localparam int IW = 2 * DW + 12;
`ifdef MCX_MUL_EN
    localparam int MUL_EXP = 42;
`else
    localparam int MUL_EXP = 6;
`endif

    localparam logic [3:0] R_ACC = 4'd0, R_DAT = 4'd1, R_P0 = 4'd2, R_P1 = 4'd3;
    localparam logic [3:0] R_X0 = 4'd4, R_X1 = 4'd5;
    localparam logic [3:0] O_MOV = 4'd1, O_ADD = 4'd2, O_SUB = 4'd3, O_MUL = 4'd4;
    localparam logic [3:0] O_NOT = 4'd5, O_TEQ = 4'd6, O_TGT = 4'd7, O_TLT = 4'd8;
    localparam logic [3:0] O_TCP = 4'd9, O_SLP = 4'd10, O_JMP = 4'd11;

    logic            clk = 1'b0;
    logic            rst_n = 1'b1;
    logic            tick = 1'b0;
    logic            prog_we = 1'b0;
    logic [3:0]      prog_addr = 4'd0;
    logic [IW-1:0]   prog_data = '0;
    logic [2*DW-1:0] p_in = '0;
    logic [2*DW-1:0] p_out;
    logic [2*DW-1:0] xin_data = '0;
    logic [1:0]      xin_valid = 2'b00;
    logic [1:0]      xin_ready;
    logic [2*DW-1:0] xout_data;
    logic [1:0]      xout_valid;
    logic [1:0]      xout_ready = 2'b11;
    logic [3:0]      pc;
    logic            sleeping;

    mcx_core dut (
        .clk(clk), .rst_n(rst_n), .tick(tick),
        .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
        .p_in(p_in), .p_out(p_out),
        .xin_data(xin_data), .xin_valid(xin_valid), .xin_ready(xin_ready),
        .xout_data(xout_data), .xout_valid(xout_valid), .xout_ready(xout_ready),
        .pc(pc), .sleeping(sleeping)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    logic [IW-1:0] img [16];

    typedef struct {
        string               name;
        logic [5:0][IW-1:0]  w;
        int                  nw;
        int                  pin1;
        int                  e_p0;
        int                  e_p1;
        int                  e_x1;
    } vec_t;
    vec_t vecs [16];
    int   nv = 0;

    function automatic logic [IW-1:0] enc(input logic [1:0] c, input logic [3:0] op,
                                          input logic ai, input logic bi,
                                          input logic [3:0] d, input int a, input int b);
        logic [DW-1:0] af, bf;
        af = DW'(a);
        bf = DW'(b);
        return {c, op, ai, bi, d, af, bf};
    endfunction

    function automatic logic [IW-1:0] movi(input int v, input logic [3:0] d);
        return enc(2'd0, O_MOV, 1'b1, 1'b1, d, v, 0);
    endfunction
    function automatic logic [IW-1:0] movr(input logic [3:0] s, input logic [3:0] d);
        return enc(2'd0, O_MOV, 1'b0, 1'b1, d, int'(s), 0);
    endfunction
    function automatic logic [IW-1:0] cmovi(input logic [1:0] c, input int v, input logic [3:0] d);
        return enc(c, O_MOV, 1'b1, 1'b1, d, v, 0);
    endfunction
    function automatic logic [IW-1:0] alui(input logic [3:0] op, input int v);
        return enc(2'd0, op, 1'b1, 1'b1, 4'd0, v, 0);
    endfunction
    function automatic logic [IW-1:0] cmpi(input logic [3:0] op, input int a, input int b);
        return enc(2'd0, op, 1'b1, 1'b1, 4'd0, a, b);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic add_vec(input string name, input logic [IW-1:0] w0, w1, w2, w3, w4, w5,
                           input int nw, input int pin1, input int e0, input int e1, input int ex);
        vecs[nv].name = name;
        vecs[nv].w[0] = w0; vecs[nv].w[1] = w1; vecs[nv].w[2] = w2;
        vecs[nv].w[3] = w3; vecs[nv].w[4] = w4; vecs[nv].w[5] = w5;
        vecs[nv].nw = nw; vecs[nv].pin1 = pin1;
        vecs[nv].e_p0 = e0; vecs[nv].e_p1 = e1; vecs[nv].e_x1 = ex;
        nv++;
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Hold reset, load img[], release reset on a falling edge (cycle 0 starts there).
    task automatic start_run();
        rst_n = 1'b0;
        tick = 1'b0;
        xin_valid = 2'b00;
        @(negedge clk);
        for (int j = 0; j < 16; j++) begin
            prog_we = 1'b1; prog_addr = 4'(j); prog_data = img[j];
            @(negedge clk);
        end
        prog_we = 1'b0;
        rst_n = 1'b1;
    endtask

    task automatic fill_halt(input int from);
        for (int j = from; j < 16; j++) img[j] = alui(O_JMP, j);
    endtask

    initial begin
        #1 rst_n = 1'b0;
        @(negedge clk);
        chk("rst_pc", int'(pc), 0);
        chk("rst_p_out", int'(p_out), 0);
        chk("rst_xout_valid", int'(xout_valid), 0);
        chk("rst_xin_ready", int'(xin_ready), 0);
        chk("rst_sleeping", int'(sleeping), 0);

        add_vec("sat_hi", alui(O_ADD, 600), alui(O_ADD, 600), movr(R_ACC, R_X1), '0, '0, '0, 3, 0, 0, 0, 999);
        add_vec("sat_lo", alui(O_SUB, 1000), alui(O_SUB, 1000), movr(R_ACC, R_X1), '0, '0, '0, 3, 0, 0, 0, -999);
        add_vec("clamp", movi(150, R_P0), movi(50, R_P1), movi(-5, R_P1), '0, '0, '0, 3, 0, 100, 0, 0);
        add_vec("pin_rd", movr(R_P1, R_ACC), alui(O_ADD, 3), movr(R_ACC, R_P0), '0, '0, '0, 3, 37, 40, 0, 0);
        add_vec("not", alui(O_NOT, 0), movr(R_ACC, R_P0), alui(O_NOT, 0), alui(O_ADD, 9), movr(R_ACC, R_P1), '0, 5, 0, 100, 9, 0);
        add_vec("teq", cmpi(O_TEQ, 4, 4), cmovi(2'd1, 20, R_P0), cmovi(2'd2, 30, R_P1), '0, '0, '0, 3, 0, 20, 0, 0);
        add_vec("tgt", cmpi(O_TGT, 2, 5), cmovi(2'd1, 20, R_P0), cmovi(2'd2, 30, R_P1), '0, '0, '0, 3, 0, 0, 30, 0);
        add_vec("tlt", cmpi(O_TLT, 2, 5), cmovi(2'd2, 11, R_P0), cmovi(2'd1, 12, R_P1), '0, '0, '0, 3, 0, 0, 12, 0);
        add_vec("never", cmovi(2'd3, 50, R_P0), movi(7, R_P1), '0, '0, '0, '0, 2, 0, 0, 7, 0);
        add_vec("jmp", alui(O_JMP, 3), movi(50, R_P0), movi(60, R_P0), movi(9, R_P1), '0, '0, 4, 0, 0, 9, 0);
        add_vec("mul", movi(6, R_ACC), alui(O_MUL, 7), movr(R_ACC, R_X1), '0, '0, '0, 3, 0, 0, 0, MUL_EXP);
        add_vec("dat_unused", movi(33, R_DAT), movr(R_DAT, R_P0), movi(44, R_P1), movr(4'd15, R_P1), '0, '0, 4, 0, 33, 0, 0);
        add_vec("signed_cmp", movi(-50, R_ACC), enc(2'd0, O_TGT, 1'b0, 1'b1, 4'd0, 0, -60), cmovi(2'd1, 1, R_P0), '0, '0, '0, 3, 0, 1, 0, 0);
        add_vec("op12_nop", movi(5, R_ACC), alui(4'd12, 7), movr(R_ACC, R_X1), '0, '0, '0, 3, 0, 0, 0, 5);
        add_vec("tcp_eq", cmpi(O_TEQ, 1, 1), cmpi(O_TCP, 4, 4), cmovi(2'd1, 1, R_P0), cmovi(2'd2, 2, R_P1), '0, '0, 4, 0, 0, 0, 0);

        // Table: run each program into a self-jump and check pins and x1 output.
        xout_ready = 2'b11;
        for (int i = 0; i < nv; i++) begin
            for (int j = 0; j < 16; j++) begin
                if (j < vecs[i].nw) img[j] = vecs[i].w[j];
                else img[j] = alui(O_JMP, j);
            end
            p_in = {DW'(vecs[i].pin1), DW'(0)};
            start_run();
            cyc(20);
            chk({vecs[i].name, "_p0"}, int'($signed(p_out[DW-1:0])), vecs[i].e_p0);
            chk({vecs[i].name, "_p1"}, int'($signed(p_out[2*DW-1:DW])), vecs[i].e_p1);
            chk({vecs[i].name, "_x1"}, int'($signed(xout_data[2*DW-1:DW])), vecs[i].e_x1);
        end
        p_in = '0;

        // mov 5 acc; add 7; mov acc p0 then nops until PC wraps.
        for (int j = 0; j < 16; j++) img[j] = '0;
        img[0] = movi(5, R_ACC); img[1] = alui(O_ADD, 7); img[2] = movr(R_ACC, R_P0);
        start_run();
        cyc(3);
        chk("prog3_p0", int'($signed(p_out[DW-1:0])), 12);
        chk("prog3_pc", int'(pc), 3);
        cyc(13);
        chk("prog3_wrap_pc", int'(pc), 0);

        // mov x0 acc stalls until xin_valid[0] arrives at cycle 10.
        img[0] = movr(R_X0, R_ACC); img[1] = movr(R_ACC, R_X1); fill_halt(2);
        xout_ready = 2'b11;
        start_run();
        cyc(1);
        chk("xrd_ready_c1", int'(xin_ready), 1);
        chk("xrd_pc_c1", int'(pc), 0);
        cyc(8);
        chk("xrd_ready_c9", int'(xin_ready), 1);
        chk("xrd_pc_c9", int'(pc), 0);
        cyc(1);
        xin_valid = 2'b01; xin_data = {DW'(0), DW'(321)};
        cyc(1);
        xin_valid = 2'b00;
        chk("xrd_pc_c11", int'(pc), 1);
        chk("xrd_ready_c11", int'(xin_ready), 0);
        cyc(1);
        chk("xwr_valid_c12", int'(xout_valid[1]), 1);
        chk("xwr_data_c12", int'($signed(xout_data[2*DW-1:DW])), 321);
        cyc(1);
        chk("xwr_valid_c13", int'(xout_valid[1]), 0);
        chk("xwr_pc_c13", int'(pc), 2);

        // tcp with equal operands clears both flags; both conditional movs skip.
        img[0] = movi(3, R_ACC); img[1] = movi(55, R_DAT);
        img[2] = enc(2'd0, O_TCP, 1'b0, 1'b1, 4'd0, 0, 3);
        img[3] = cmovi(2'd1, 1, R_DAT); img[4] = cmovi(2'd2, 2, R_DAT);
        img[5] = movr(R_DAT, R_P0); fill_halt(6);
        start_run();
        cyc(4);
        chk("tcp_pc_c4", int'(pc), 4);
        cyc(1);
        chk("tcp_pc_c5", int'(pc), 5);
        cyc(1);
        chk("tcp_dat", int'($signed(p_out[DW-1:0])), 55);

        // slp 3 with a tick every 5 cycles.
        img[0] = alui(O_SLP, 3); img[1] = movi(77, R_P0); fill_halt(2);
        start_run();
        for (int k = 1; k <= 17; k++) begin
            cyc(1);
            if (k == 1) begin
                chk("slp_sleep_c1", int'(sleeping), 1);
                chk("slp_pc_c1", int'(pc), 0);
            end
            if (k == 11) chk("slp_sleep_c11", int'(sleeping), 1);
            if (k == 15) chk("slp_sleep_c15", int'(sleeping), 1);
            if (k == 16) begin
                chk("slp_sleep_c16", int'(sleeping), 0);
                chk("slp_pc_c16", int'(pc), 1);
            end
            if (k == 17) chk("slp_p0_c17", int'($signed(p_out[DW-1:0])), 77);
            tick = (k % 5 == 0);
        end
        tick = 1'b0;

        // Reset while x1 output is pending; program must survive.
        img[0] = movi(9, R_X1); img[1] = movi(4, R_P0); fill_halt(2);
        xout_ready = 2'b00;
        start_run();
        cyc(2);
        chk("xrst_valid_before", int'(xout_valid), 2);
        #2 rst_n = 1'b0;
        #1;
        chk("xrst_valid_after", int'(xout_valid), 0);
        chk("xrst_pc_after", int'(pc), 0);
        @(negedge clk);
        rst_n = 1'b1;
        xout_ready = 2'b11;
        cyc(4);
        chk("xrst_prog_x1", int'($signed(xout_data[2*DW-1:DW])), 9);
        chk("xrst_prog_p0", int'($signed(p_out[DW-1:0])), 4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
